hub_arb: RTL

- Time-slot arbiter that shares the single-port hub memory (32-bit words, 14-bit word address, byte-write enables) between 8 cogs.
- Rotates a slot pointer on every bus-enable cycle and captures the request of the slot owner.
- Drives the memory command for one bus cycle, then returns read data with a one-clock acknowledge to the owning cog.
- Sits between the cog array and hub memory.

---
 rtl/hub_pkg.sv | 25 ++
 rtl/hub_rr_pick.sv | 30 +++
 rtl/hub_arb.sv | 136 +++++++++++++
 3 files changed

// File: rtl/hub_pkg.sv
// Shared types and constants for the hub memory arbiter.
package hub_pkg;

    localparam int NCOGS  = 8;
    localparam int HUB_AW = 14;
    localparam int HUB_DW = 32;
    localparam int HUB_WB = 4;
    localparam int COG_W  = 3;

    typedef logic [COG_W-1:0] cog_id_t;

    localparam cog_id_t COG_ONE = 3'd1;

    typedef struct packed {
        logic              w;
        logic [HUB_WB-1:0] wb;
        logic [HUB_AW-1:0] a;
        logic [HUB_DW-1:0] d;
    } hub_cmd_t;

    function automatic logic [NCOGS-1:0] cog_onehot(input cog_id_t id);
        cog_onehot = 8'd1 << id;
    endfunction

endpackage

// File: rtl/hub_rr_pick.sv
// Cyclic priority picker: first set bit of req_mask at or after start.
module hub_rr_pick
    import hub_pkg::*;
(
    input  logic [NCOGS-1:0] req_mask,
    input  cog_id_t          start,
    output logic             valid,
    output cog_id_t          idx
);

    cog_id_t cand_s;

    // Scan from farthest to nearest so the nearest qualifying cog wins.
    always_comb begin
        valid  = 1'b0;
        idx    = start;
        cand_s = start;
        for (int k = NCOGS - 1; k >= 0; k--) begin
            cand_s = start + cog_id_t'(k);
            if (req_mask[cand_s]) begin
                valid = 1'b1;
                idx   = cand_s;
            end else begin
                valid = valid;
                idx   = idx;
            end
        end
    end

endmodule

// File: rtl/hub_arb.sv
// Time-slot arbiter sharing hub memory between cogs; HUB_SKIP_IDLE_EN
// selects work-conserving slot skipping instead of strict fixed slots.
module hub_arb #(
    parameter int NCOGS = hub_pkg::NCOGS,
    parameter int AW    = hub_pkg::HUB_AW,
    parameter int DW    = hub_pkg::HUB_DW
) (
    input  logic                  clk_cog,
    input  logic                  res,
    input  logic                  ena_bus,
    input  logic [NCOGS-1:0]      cog_req,
    input  logic [NCOGS-1:0]      cog_w,
    input  logic [NCOGS*4-1:0]    cog_wb,
    input  logic [NCOGS*AW-1:0]   cog_a,
    input  logic [NCOGS*DW-1:0]   cog_d,
    output logic [NCOGS-1:0]      cog_ack,
    output logic [DW-1:0]         cog_q,
    output logic                  mem_ena,
    output logic                  mem_w,
    output logic [3:0]            mem_wb,
    output logic [AW-1:0]         mem_a,
    output logic [DW-1:0]         mem_d,
    input  logic [DW-1:0]         mem_q,
    output logic [2:0]            slot
);

    import hub_pkg::*;

    cog_id_t          slot_r;
    cog_id_t          cmd_cog_r;
    cog_id_t          rd_cog_r;
    logic             cmd_valid_r;
    logic             rd_pulse_r;
    logic [NCOGS-1:0] busy_r;
    logic [NCOGS-1:0] ack_r;
    logic [DW-1:0]    q_r;
    hub_cmd_t         cmd_r;

    logic             grant_s;
    cog_id_t          grant_cog_s;
    cog_id_t          slot_nxt_s;
    hub_cmd_t         sel_cmd_s;

`ifdef HUB_SKIP_IDLE_EN
    logic    pick_valid_s;
    cog_id_t pick_idx_s;

    hub_rr_pick u_pick (
        .req_mask (cog_req & ~busy_r),
        .start    (slot_r),
        .valid    (pick_valid_s),
        .idx      (pick_idx_s)
    );

    // Grant the nearest idle requester and restart rotation just past it.
    always_comb begin
        grant_s     = pick_valid_s;
        grant_cog_s = pick_idx_s;
        if (pick_valid_s) begin
            slot_nxt_s = pick_idx_s + COG_ONE;
        end else begin
            slot_nxt_s = slot_r + COG_ONE;
        end
    end
`else
    // Fixed slots: only the slot owner may be granted; idle slots stay empty.
    always_comb begin
        grant_s     = cog_req[slot_r] & ~busy_r[slot_r];
        grant_cog_s = slot_r;
        slot_nxt_s  = slot_r + COG_ONE;
    end
`endif

    // Extract the granted cog's command fields from the flat buses.
    always_comb begin
        sel_cmd_s.w  = cog_w[grant_cog_s];
        sel_cmd_s.wb = cog_wb[int'(grant_cog_s) * HUB_WB +: HUB_WB];
        sel_cmd_s.a  = cog_a[int'(grant_cog_s) * AW +: AW];
        sel_cmd_s.d  = cog_d[int'(grant_cog_s) * DW +: DW];
    end

    // Issue stage: slot rotation, grant capture and per-cog busy tracking.
    always_ff @(posedge clk_cog) begin
        if (res) begin
            slot_r      <= 3'd0;
            cmd_valid_r <= 1'b0;
            cmd_cog_r   <= 3'd0;
            cmd_r       <= {$bits(hub_cmd_t){1'b0}};
            busy_r      <= {NCOGS{1'b0}};
        end else begin
            // Busy drops the clock after ack, so a cog that releases req on ack
            // is never seen as a fresh request.
            busy_r <= (busy_r & ~ack_r)
                    | ((ena_bus && grant_s) ? cog_onehot(grant_cog_s) : {NCOGS{1'b0}});
            if (ena_bus) begin
                slot_r      <= slot_nxt_s;
                cmd_valid_r <= grant_s;
                if (grant_s) begin
                    cmd_cog_r <= grant_cog_s;
                    cmd_r     <= sel_cmd_s;
                end
            end
        end
    end

    // Execute/return stage: one-clock read pulse, then ack and data capture.
    always_ff @(posedge clk_cog) begin
        if (res) begin
            rd_pulse_r <= 1'b0;
            rd_cog_r   <= 3'd0;
            ack_r      <= {NCOGS{1'b0}};
            q_r        <= {DW{1'b0}};
        end else begin
            rd_pulse_r <= ena_bus & cmd_valid_r;
            if (ena_bus) begin
                rd_cog_r <= cmd_cog_r;
            end
            if (rd_pulse_r) begin
                ack_r <= cog_onehot(rd_cog_r);
                q_r   <= mem_q;
            end else begin
                ack_r <= {NCOGS{1'b0}};
            end
        end
    end

    assign mem_ena = ena_bus & cmd_valid_r;
    assign mem_w   = cmd_r.w;
    assign mem_wb  = cmd_r.wb;
    assign mem_a   = cmd_r.a;
    assign mem_d   = cmd_r.d;
    assign cog_ack = ack_r;
    assign cog_q   = q_r;
    assign slot    = slot_r;

endmodule
